// File: rtl/sap2_mini_ctrl.sv
// SAP2-mini control sequencer: T-state ring, opcode decode and 30-bit control word.
// Optional single-step mode is enabled by defining SINGLE_STEP_EN (adds run/step inputs).
module sap2_mini_ctrl #(
  parameter logic [5:0] ALU_ADD = 6'b100100,
  parameter logic [5:0] ALU_SUB = 6'b011001
) (
  input  logic        clk,
  input  logic        clr,
`ifdef SINGLE_STEP_EN
  input  logic        run,
  input  logic        step,
`endif
  input  logic [7:0]  ins,
  input  logic        am,
  input  logic        az,
  input  logic        xm,
  input  logic        xz,
  output logic [29:0] con,
  output logic        hlt,
  output logic [5:0]  t
);

  typedef enum logic [6:0] {
    S_T1   = 7'b0000001,
    S_T2   = 7'b0000010,
    S_T3   = 7'b0000100,
    S_T4   = 7'b0001000,
    S_T5   = 7'b0010000,
    S_T6   = 7'b0100000,
    S_HALT = 7'b1000000
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JZ,
    OP_JM,  OP_JXZ, OP_CALL, OP_RET, OP_IN, OP_OUT, OP_XOP, OP_HLT
  } op_t;

  localparam logic [29:0] M_LP  = 30'(1) << 29;
  localparam logic [29:0] M_CP  = 30'(1) << 28;
  localparam logic [29:0] M_EP  = 30'(1) << 27;
  localparam logic [29:0] M_LS  = 30'(1) << 26;
  localparam logic [29:0] M_ES  = 30'(1) << 24;
  localparam logic [29:0] M_LM  = 30'(1) << 23;
  localparam logic [29:0] M_WE  = 30'(1) << 22;
  localparam logic [29:0] M_CE  = 30'(1) << 21;
  localparam logic [29:0] M_LD  = 30'(1) << 20;
  localparam logic [29:0] M_LI  = 30'(1) << 18;
  localparam logic [29:0] M_EI  = 30'(1) << 17;
  localparam logic [29:0] M_EN  = 30'(1) << 15;
  localparam logic [29:0] M_LA  = 30'(1) << 14;
  localparam logic [29:0] M_EA  = 30'(1) << 13;
  localparam logic [29:0] M_EU  = 30'(1) << 6;
  localparam logic [29:0] M_LB  = 30'(1) << 5;
  localparam logic [29:0] M_INX = 30'(1) << 3;
  localparam logic [29:0] M_DEX = 30'(1) << 2;
  localparam logic [29:0] M_LO  = 30'(1) << 0;
  localparam logic [29:0] M_ADD = 30'(ALU_ADD) << 7;
  localparam logic [29:0] M_SUB = 30'(ALU_SUB) << 7;

  state_t      r_state;
  state_t      w_next;
  logic [29:0] w_con;
  logic        w_stall;
  op_t         w_op;
  logic        w_unused_xm;

  assign w_op        = op_t'(ins[7:4]);
  assign w_unused_xm = xm;

`ifdef SINGLE_STEP_EN
  logic r_step_d;
  logic r_wait;
  logic w_step_rise;

  assign w_step_rise = step & ~r_step_d;
  assign w_stall     = r_wait & (r_state == S_T1) & ~run & ~w_step_rise;

  // r_wait arms when an instruction ends; a reset clears it so fetch starts at once.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_step_d <= 1'b0;
      r_wait   <= 1'b0;
    end else begin
      r_step_d <= step;
      if (r_state != S_T1 && w_next == S_T1)
        r_wait <= 1'b1;
      else if (r_state == S_T1 && !w_stall)
        r_wait <= 1'b0;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_con  = '0;
    w_next = r_state;
    case (r_state)
      S_T1: begin w_con = M_EP | M_LM;        w_next = S_T2; end
      S_T2: begin w_con = M_CE | M_LI | M_CP; w_next = S_T3; end
      S_T3: begin
        w_next = S_T1;
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin w_con = M_EI | M_LM; w_next = S_T4; end
          OP_LDI:  w_con = M_EI | M_LA;
          OP_JMP:  w_con = M_EI | M_LP;
          OP_JZ:   w_con = az ? (M_EI | M_LP) : '0;
          OP_JM:   w_con = am ? (M_EI | M_LP) : '0;
          OP_JXZ:  w_con = xz ? (M_EI | M_LP) : '0;
          OP_CALL: begin w_con = M_EP | M_LS; w_next = S_T4; end
          OP_RET:  w_con = M_ES | M_LP;
          OP_IN:   w_con = M_EN | M_LA;
          OP_OUT:  w_con = M_EA | M_LO;
          OP_XOP:  w_con = (ins[3:0] == 4'd0) ? M_INX : (ins[3:0] == 4'd1) ? M_DEX : '0;
          OP_HLT:  w_next = S_HALT;
          default: w_con = '0;
        endcase
      end
      S_T4: begin
        w_next = S_T1;
        case (w_op)
          OP_LDA:         w_con = M_CE | M_LA;
          OP_ADD, OP_SUB: begin w_con = M_CE | M_LB; w_next = S_T5; end
          OP_STA:         begin w_con = M_EA | M_LD; w_next = S_T5; end
          OP_CALL:        w_con = M_EI | M_LP;
          default:        w_con = '0;
        endcase
      end
      S_T5: begin
        w_next = S_T1;
        case (w_op)
          OP_ADD:  w_con = M_EU | M_LA | M_ADD;
          OP_SUB:  w_con = M_EU | M_LA | M_SUB;
          OP_STA:  w_con = M_WE;
          default: w_con = '0;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_T1;
    endcase
    if (w_stall) begin
      w_con  = '0;
      w_next = S_T1;
    end
  end

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_T1;
    else     r_state <= w_next;
  end

  // Masking with clr keeps a STA caught at T5 from writing during reset.
  assign con = clr ? '0 : w_con;
  assign hlt = (r_state == S_HALT);
  assign t   = r_state[5:0];

endmodule

// File: tb/tb_sap2_mini_ctrl.sv
// Scoreboard bench for sap2_mini_ctrl: the driver pushes per-cycle expectations from an
// instruction-level model, and a negedge monitor pops and compares them.
module tb_sap2_mini_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  ins = 8'h00;
  logic        am = 1'b0, az = 1'b0, xm = 1'b0, xz = 1'b0;
  logic [29:0] con;
  logic        hlt;
  logic [5:0]  t;
`ifdef SINGLE_STEP_EN
  logic        run  = 1'b1;
  logic        step = 1'b0;
`endif

  sap2_mini_ctrl dut (
    .clk (clk),
    .clr (clr),
`ifdef SINGLE_STEP_EN
    .run (run),
    .step(step),
`endif
    .ins (ins),
    .am  (am),
    .az  (az),
    .xm  (xm),
    .xz  (xz),
    .con (con),
    .hlt (hlt),
    .t   (t)
  );

  always #5 clk = ~clk;

  // Control-word bits, listed from bit 29 down to bit 0.
  localparam logic [29:0] LP = 30'(1) << 29, CP = 30'(1) << 28, EP = 30'(1) << 27;
  localparam logic [29:0] LS = 30'(1) << 26, ES = 30'(1) << 24, LM = 30'(1) << 23;
  localparam logic [29:0] WE = 30'(1) << 22, CE = 30'(1) << 21, LD = 30'(1) << 20;
  localparam logic [29:0] ED = 30'(1) << 19, LI = 30'(1) << 18, EI = 30'(1) << 17;
  localparam logic [29:0] EN = 30'(1) << 15, LA = 30'(1) << 14, EA = 30'(1) << 13;
  localparam logic [29:0] EU = 30'(1) << 6,  LB = 30'(1) << 5,  INX = 30'(1) << 3;
  localparam logic [29:0] DEX = 30'(1) << 2, EX = 30'(1) << 1,  LO = 30'(1) << 0;
  localparam logic [29:0] ALU_ADD_F = 30'(6'b100100) << 7;
  localparam logic [29:0] ALU_SUB_F = 30'(6'b011001) << 7;
  localparam logic [29:0] DRIVERS = EP | ES | CE | ED | EI | EN | EA | EU | EX;

  typedef struct {
    logic [5:0]  t;
    logic [29:0] con;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   flag_mode = -1;  // -1 random flags, 0 all clear, 1 all set

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, expv);
    end
  endtask

  // Clocks an instruction takes from T1 to its end.
  function automatic int instr_len(input int op);
    case (op)
      1, 10:   return 4;
      2, 3, 4: return 5;
      default: return 3;
    endcase
  endfunction

  // Control word for a given clock of an instruction, straight from the instruction table.
  function automatic logic [29:0] model_con(input int op, input int sub, input int k,
                                            input logic f_az, input logic f_am, input logic f_xz);
    if (k == 0) return EP | LM;
    if (k == 1) return CE | LI | CP;
    case (op)
      1:  return (k == 2) ? (EI | LM) : (CE | LA);
      2:  return (k == 2) ? (EI | LM) : (k == 3) ? (CE | LB) : (EU | LA | ALU_ADD_F);
      3:  return (k == 2) ? (EI | LM) : (k == 3) ? (CE | LB) : (EU | LA | ALU_SUB_F);
      4:  return (k == 2) ? (EI | LM) : (k == 3) ? (EA | LD) : WE;
      5:  return EI | LA;
      6:  return EI | LP;
      7:  return f_az ? (EI | LP) : 30'd0;
      8:  return f_am ? (EI | LP) : 30'd0;
      9:  return f_xz ? (EI | LP) : 30'd0;
      10: return (k == 2) ? (EP | LS) : (EI | LP);
      11: return ES | LP;
      12: return EN | LA;
      13: return EA | LO;
      14: return (sub == 0) ? INX : (sub == 1) ? DEX : 30'd0;
      default: return 30'd0;
    endcase
  endfunction

  task automatic push_exp(input logic [5:0] te, input logic [29:0] ce_v, input logic he);
    exp_t e;
    e.t = te; e.con = ce_v; e.hlt = he;
    q.push_back(e);
  endtask

  task automatic step_cycle(input logic c, input logic [7:0] i);
    @(posedge clk);
    #1;
    clr = c;
    ins = i;
    if (flag_mode < 0) begin
      am = 1'($urandom); az = 1'($urandom); xm = 1'($urandom); xz = 1'($urandom);
    end else begin
      am = 1'(flag_mode); az = 1'(flag_mode); xm = 1'(flag_mode); xz = 1'(flag_mode);
    end
  endtask

  // One instruction starting in T1; abort_k >= 0 asserts clr on that clock.
  task automatic run_instr(input int op, input int sub, input int abort_k, input int halt_cycles);
    logic [7:0] iv;
    int len;
    iv  = {4'(op), 4'(sub)};
    len = instr_len(op);
    for (int k = 0; k < len; k++) begin
      if (k == abort_k) begin
        step_cycle(1'b1, iv);
        push_exp(6'b1 << k, 30'd0, 1'b0);
        return;
      end
      step_cycle(1'b0, iv);
      push_exp(6'b1 << k, (op == 15 && k == 2) ? 30'd0 : model_con(op, sub, k, az, am, xz), 1'b0);
    end
    if (op == 15) begin
      for (int h = 0; h < halt_cycles; h++) begin
        step_cycle(1'b0, 8'($urandom));
        push_exp(6'd0, 30'd0, 1'b1);
      end
      step_cycle(1'b1, iv);
      push_exp(6'd0, 30'd0, 1'b1);
    end
  endtask

  // Monitor: pops one expectation per clock and checks the bus-rule invariants too.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("t",   32'(t),   32'(e.t));
        check("con", 32'(con), 32'(e.con));
        check("hlt", 32'(hlt), 32'(e.hlt));
        check("one_driver", 32'($countones(con & DRIVERS) <= 1), 32'd1);
        check("lp_excl_cp", 32'(con[29] & con[28]), 32'd0);
      end
    end
  end

  initial begin
    int op, len, ab;
    clr = 1'b1;
    repeat (2) begin
      step_cycle(1'b1, 8'h00);
      push_exp(6'b000001, 30'd0, 1'b0);
    end
    run_instr(0, 0, -1, 0);
    run_instr(2, 5, -1, 0);
    run_instr(3, 9, -1, 0);
    flag_mode = 0;
    run_instr(7, 0, -1, 0); run_instr(8, 0, -1, 0); run_instr(9, 0, -1, 0);
    flag_mode = 1;
    run_instr(7, 0, -1, 0); run_instr(8, 0, -1, 0); run_instr(9, 0, -1, 0);
    flag_mode = -1;
    run_instr(10, 3, -1, 0);
    run_instr(11, 0, -1, 0);
    for (int o = 1; o <= 14; o++) run_instr(o, o & 1, -1, 0);
    run_instr(14, 5, -1, 0);
    run_instr(15, 0, -1, 12);
    run_instr(4, 0, 4, 0);
    run_instr(0, 0, -1, 0);
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 15);
      len = instr_len(op);
      ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      if (op == 15 && ab < 0 && $urandom_range(0, 2) != 0) op = 0;
      run_instr(op, $urandom_range(0, 3), ab, $urandom_range(1, 6));
    end
    @(negedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap2_mini_ctrl.md
Name: sap2_mini_ctrl

Overview:
Control sequencer for the SAP2-mini datapath. Steps a T-state ring through fetch and execute, decodes the 4-bit opcode from the instruction register, and evaluates the accumulator and X flags. It drives the 30-bit control word that enables and loads every datapath register, RAM, ALU and port. It fills the control-unit slot beside pc, sc, mar, ram256x12, mdr, ir, i, acc, alu, b, x and output_port.

Parameters:
ALU_ADD, 6'b100100, {s3,s2,s1,s0,m,ci} driven during ADD
ALU_SUB, 6'b011001, {s3,s2,s1,s0,m,ci} driven during SUB

Ports:
clk  in  1  system clock; all state changes on the rising edge
clr  in  1  synchronous active-high reset
ins  in  8  ir to_ctrl (ir[11:4]); opcode = ins[7:4], subop = ins[3:0]
am   in  1  accumulator negative flag
az   in  1  accumulator zero flag
xm   in  1  X negative flag; sampled by no opcode
xz   in  1  X zero flag
con  out 30 control word, bits 29..0 = {lp,cp,ep, ls,cs,es, lm, we,ce, ld,ed, li,ei, ln,en, la,ea, s3,s2,s1,s0,m,ci,eu, lb, lx,inx,dex,ex, lo}
hlt  out 1  high while halted
t    out 6  one-hot T-state (t[0]=T1 .. t[5]=T6), for debug and bench use

Behaviour:
- One-hot state T1..T6 plus HALT. Reset puts the block in T1 with hlt=0.
- con is a combinational function of (state, opcode, flags). It is forced to 0 while clr=1. Every bit not listed for a T-state is 0.
- Fetch, every instruction:
  - T1: ep, lm.
  - T2: ce, li, cp.
- Execute starts at T3. "end" means the next state is T1.
- Execute sequences by opcode:
  - 0 NOP: T3 no signals, end.
  - 1 LDA: T3 ei, lm. T4 ce, la, end.
  - 2 ADD: T3 ei, lm. T4 ce, lb. T5 eu, la, {s..ci}=ALU_ADD, end.
  - 3 SUB: same as ADD, but T5 uses ALU_SUB.
  - 4 STA: T3 ei, lm. T4 ea, ld. T5 we, end.
  - 5 LDI: T3 ei, la, end.
  - 6 JMP: T3 ei, lp, end.
  - 7 JZ / 8 JM / 9 JXZ: T3 ei, lp only if az / am / xz respectively, else no signals; end either way.
  - A CALL: T3 ep, ls. T4 ei, lp, end. Single-level return; a nested CALL overwrites sc.
  - B RET: T3 es, lp, end.
  - C IN: T3 en, la, end.
  - D OUT: T3 ea, lo, end.
  - E XOP: T3 inx if subop=0, dex if subop=1, no signals otherwise; end.
  - F HLT: T3 transitions to HALT.
- HALT: con=0, hlt=1, t=0. Only clr leaves HALT.
- Flags are sampled combinationally during T3 only.
- At most one bus driver (ep, es, ce, ed, ei, en, ea, eu, ex) is high in any state.
- In any state where lp=1, cp=0.
- Instruction length: 3 to 5 clocks.
- Reset mid-instruction: the next edge with clr=1 goes to T1 and the in-flight op is aborted. A STA caught at T5 with clr=1 does not write, because we is masked.

Optional Feature:
SINGLE_STEP_EN
- Enabled: adds input ports run and step. On entering T1 from an end, the block holds in T1 with con=0 while run=0, until a rising edge of step (edge-detected, one register). run=1 free-runs. Reset still lands in T1 and starts fetching immediately.
- Disabled: the ports are absent and the block always free-runs.

Test Plan:
1. clr=1 for 2 clocks, then release, ins=8'h00 -> t=000001, con=0 during reset. T1 con has ep,lm only. T2 has ce,li,cp. T3 all zero. Back to T1 at cycle 4.
2. ins=8'h2x -> T3 {ei,lm}, T4 {ce,lb}, T5 {eu,la} with s..ci=100100. Return to T1 after 5 clocks.
3. ins=8'h7x: az=0 gives T3 con=0. az=1 gives T3 {ei,lp}. Repeat with 8'h8x/am and 8'h9x/xz.
4. ins=8'hAx -> T3 {ep,ls}, T4 {ei,lp}. Then ins=8'hBx -> T3 {es,lp}.
5. ins=8'hFx -> hlt=1 from the 4th edge and stays 10+ cycles with con=0. clr pulse -> T1, hlt=0.
6. ins=8'h4x with clr asserted in T5 -> we=0 that cycle, t=T1 next cycle. Also check the one-driver rule every cycle of a random opcode stream.
